// File: rtl/tick_gen.sv
// ---------------------------------------------------------------------------
// tick_gen
//
// Multi-channel programmable tick generator. Each channel counts down from a
// run-time divisor and emits a registered one-cycle pulse every div+1 cycles
// (periodic) or once (one-shot). A global sync pulse restarts every enabled
// channel so channels with equal divisors tick together.
//
// Ports:
//   clk        - system clock, rising edge
//   rst_n      - asynchronous active-low reset
//   i_wr       - configuration write strobe (one cycle per write)
//   i_wr_ch    - target channel of the write (>= CHANNELS is ignored)
//   i_wr_div   - divisor to load (period = div+1 cycles)
//   i_wr_mode  - 0 = periodic, 1 = one-shot
//   i_en       - per-channel run enable (level)
//   i_sync     - global restart pulse
//   o_tick     - per-channel registered tick pulses
//   o_busy     - per-channel "state is RUN"
//   o_tick_cnt - per-channel saturating tick counters, channel n at
//                [n*CNT_W +: CNT_W]
//
// Build option:
//   TICK_GEN_STATS_EN - when defined, builds the per-channel tick counters;
//                       otherwise o_tick_cnt is tied to zero.
// ---------------------------------------------------------------------------
module tick_gen #(
  parameter int CHANNELS = 4,
  parameter int DIV_W    = 16,
  parameter int CNT_W    = 8,
  parameter int CH_W     = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      i_wr,
  input  logic [CH_W-1:0]           i_wr_ch,
  input  logic [DIV_W-1:0]          i_wr_div,
  input  logic                      i_wr_mode,
  input  logic [CHANNELS-1:0]       i_en,
  input  logic                      i_sync,
  output logic [CHANNELS-1:0]       o_tick,
  output logic [CHANNELS-1:0]       o_busy,
  output logic [CHANNELS*CNT_W-1:0] o_tick_cnt
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  for (genvar g = 0; g < CHANNELS; g++) begin : g_ch
    state_e           state_q, state_d;
    logic [DIV_W-1:0] cnt_q, cnt_d;
    logic [DIV_W-1:0] div_q, div_d;
    logic             mode_q, mode_d;
    logic             tick_q, tick_d;
    logic             wr_hit;

    // Out-of-range channel numbers never compare equal to a real channel,
    // so they are dropped without any extra decoding.
    assign wr_hit = i_wr && (i_wr_ch == CH_W'(g));

    // State register: FSM state, down-counter, configuration and tick flop.
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        state_q <= ST_IDLE;
        cnt_q   <= '0;
        div_q   <= '0;
        mode_q  <= 1'b0;
        tick_q  <= 1'b0;
      end else begin
        state_q <= state_d;
        cnt_q   <= cnt_d;
        div_q   <= div_d;
        mode_q  <= mode_d;
        tick_q  <= tick_d;
      end
    end

    // Next-state logic. Priority: write, then enable low, then sync, then
    // the normal state behaviour. Reloading from div_q on the terminal
    // count keeps the period at exactly div+1 with no drift.
    always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      div_d   = div_q;
      mode_d  = mode_q;
      if (wr_hit) begin
        div_d   = i_wr_div;
        mode_d  = i_wr_mode;
        cnt_d   = i_wr_div;
        state_d = ST_IDLE;
      end else if (!i_en[g]) begin
        state_d = ST_IDLE;
      end else if (i_sync) begin
        cnt_d   = div_q;
        state_d = ST_RUN;
      end else begin
        case (state_q)
          ST_IDLE: begin
            cnt_d   = div_q;
            state_d = ST_RUN;
          end
          ST_RUN: begin
            if (cnt_q == '0) begin
              cnt_d = div_q;
              if (mode_q) begin
                state_d = ST_DONE;
              end
            end else begin
              cnt_d = cnt_q - DIV_W'(1);
            end
          end
          default: begin
            state_d = state_q;
          end
        endcase
      end
    end

    // Output logic: a tick is registered only from an undisturbed RUN state
    // at terminal count, so a write, enable drop or sync suppresses it.
    always_comb begin
      tick_d = 1'b0;
      if (!wr_hit && i_en[g] && !i_sync && (state_q == ST_RUN) && (cnt_q == '0)) begin
        tick_d = 1'b1;
      end
    end

    assign o_tick[g] = tick_q;
    assign o_busy[g] = (state_q == ST_RUN);

`ifdef TICK_GEN_STATS_EN
    logic [CNT_W-1:0] stat_q;

    // Saturating count of ticks seen on o_tick; cleared by a write.
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        stat_q <= '0;
      end else if (wr_hit) begin
        stat_q <= '0;
      end else if (tick_q && (stat_q != '1)) begin
        stat_q <= stat_q + CNT_W'(1);
      end
    end

    assign o_tick_cnt[g*CNT_W +: CNT_W] = stat_q;
`else
    assign o_tick_cnt[g*CNT_W +: CNT_W] = '0;
`endif
  end

endmodule

// File: tb/tb_tick_gen.sv
// ---------------------------------------------------------------------------
// tb_tick_gen
//
// Self-checking bench for tick_gen. Directed scenarios followed by random
// traffic; every cycle the outputs are compared with a reference model that
// tracks, per channel, whether it is running and the absolute cycle number
// of its next tick.
// ---------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_tick_gen;

  localparam int CH    = 3;
  localparam int CH_W  = 2;
  localparam int DIV_W = 8;
  localparam int CNT_W = 4;
  localparam int CNT_MAX = (1 << CNT_W) - 1;

  logic                clk;
  logic                rst_n;
  logic                i_wr;
  logic [CH_W-1:0]     i_wr_ch;
  logic [DIV_W-1:0]    i_wr_div;
  logic                i_wr_mode;
  logic [CH-1:0]       i_en;
  logic                i_sync;
  logic [CH-1:0]       o_tick;
  logic [CH-1:0]       o_busy;
  logic [CH*CNT_W-1:0] o_tick_cnt;

  int checks = 0;
  int errors = 0;

  // Reference model state
  int cyc;
  int m_div  [CH];
  bit m_mode [CH];
  bit m_run  [CH];
  bit m_done [CH];
  int m_next [CH];
  bit m_tick [CH];
  int m_cnt  [CH];

  tick_gen #(
    .CHANNELS(CH),
    .DIV_W(DIV_W),
    .CNT_W(CNT_W)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .i_wr(i_wr),
    .i_wr_ch(i_wr_ch),
    .i_wr_div(i_wr_div),
    .i_wr_mode(i_wr_mode),
    .i_en(i_en),
    .i_sync(i_sync),
    .o_tick(o_tick),
    .o_busy(o_busy),
    .o_tick_cnt(o_tick_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  function automatic void resetModel();
    for (int i = 0; i < CH; i++) begin
      m_div[i]  = 0;
      m_mode[i] = 1'b0;
      m_run[i]  = 1'b0;
      m_done[i] = 1'b0;
      m_next[i] = 0;
      m_tick[i] = 1'b0;
      m_cnt[i]  = 0;
    end
  endfunction

  // Advance the model by one clock edge using the inputs the DUT sampled.
  function automatic void updateModel();
    cyc++;
    for (int i = 0; i < CH; i++) begin
      bit prev_tick;
      prev_tick = m_tick[i];
      if (i_wr && (int'(i_wr_ch) == i)) begin
        m_div[i]  = int'(i_wr_div);
        m_mode[i] = i_wr_mode;
        m_run[i]  = 1'b0;
        m_done[i] = 1'b0;
        m_tick[i] = 1'b0;
        m_cnt[i]  = 0;
      end else begin
        if (prev_tick && (m_cnt[i] < CNT_MAX)) m_cnt[i]++;
        m_tick[i] = 1'b0;
        if (!i_en[i]) begin
          m_run[i]  = 1'b0;
          m_done[i] = 1'b0;
        end else if (i_sync) begin
          m_run[i]  = 1'b1;
          m_done[i] = 1'b0;
          m_next[i] = cyc + m_div[i] + 1;
        end else if (m_run[i]) begin
          if (cyc == m_next[i]) begin
            m_tick[i] = 1'b1;
            m_next[i] = cyc + m_div[i] + 1;
            if (m_mode[i]) begin
              m_run[i]  = 1'b0;
              m_done[i] = 1'b1;
            end
          end
        end else if (!m_done[i]) begin
          m_run[i]  = 1'b1;
          m_next[i] = cyc + m_div[i] + 1;
        end
      end
    end
  endfunction

  task automatic checkOutput();
    logic [CH-1:0]       et;
    logic [CH-1:0]       eb;
    logic [CH*CNT_W-1:0] ec;
    for (int i = 0; i < CH; i++) begin
      et[i] = m_tick[i];
      eb[i] = m_run[i];
`ifdef TICK_GEN_STATS_EN
      ec[i*CNT_W +: CNT_W] = CNT_W'(m_cnt[i]);
`else
      ec[i*CNT_W +: CNT_W] = '0;
`endif
    end
    checks++;
    assert (o_tick === et) else begin
      errors++;
      $error("[TB] FAIL tick cyc=%0d observed=%b expected=%b", cyc, o_tick, et);
    end
    checks++;
    assert (o_busy === eb) else begin
      errors++;
      $error("[TB] FAIL busy cyc=%0d observed=%b expected=%b", cyc, o_busy, eb);
    end
    checks++;
    assert (o_tick_cnt === ec) else begin
      errors++;
      $error("[TB] FAIL tick_cnt cyc=%0d observed=%h expected=%h", cyc, o_tick_cnt, ec);
    end
  endtask

  // Drive one cycle of inputs, clock it, update the model and compare.
  task automatic applyStimulus(input logic wr, input int ch, input int div,
                               input logic mode, input logic [CH-1:0] en,
                               input logic sync);
    i_wr      = wr;
    i_wr_ch   = CH_W'(ch);
    i_wr_div  = DIV_W'(div);
    i_wr_mode = mode;
    i_en      = en;
    i_sync    = sync;
    @(posedge clk);
    updateModel();
    #1;
    checkOutput();
  endtask

  task automatic runCycles(input int n, input logic [CH-1:0] en);
    for (int c = 0; c < n; c++) applyStimulus(1'b0, 0, 0, 1'b0, en, 1'b0);
  endtask

  initial begin
    int waited;
    logic [CH-1:0] en_v;

    rst_n = 1'b0;
    i_wr = 1'b0; i_wr_ch = '0; i_wr_div = '0; i_wr_mode = 1'b0;
    i_en = '0; i_sync = 1'b0;
    cyc = 0;
    resetModel();
    #3;
    checkOutput();
    @(posedge clk);
    #1;
    rst_n = 1'b1;

    runCycles(3, 3'b000);

    // ch0 periodic, div 15
    applyStimulus(1'b1, 0, 15, 1'b0, 3'b000, 1'b0);
    runCycles(40, 3'b001);

    // ch1 one-shot, div 3, then re-arm by toggling enable
    applyStimulus(1'b1, 1, 3, 1'b1, 3'b001, 1'b0);
    runCycles(12, 3'b011);
    runCycles(1, 3'b001);
    runCycles(10, 3'b011);

    // ch0/ch2 div 4 enabled two cycles apart, then aligned by sync
    applyStimulus(1'b1, 0, 4, 1'b0, 3'b011, 1'b0);
    applyStimulus(1'b1, 2, 4, 1'b0, 3'b011, 1'b0);
    runCycles(2, 3'b011);
    runCycles(2, 3'b111);
    applyStimulus(1'b0, 0, 0, 1'b0, 3'b111, 1'b1);
    runCycles(20, 3'b111);

    // Write ch0 in the cycle its tick is due
    waited = 0;
    while (!(m_run[0] && (m_next[0] == cyc + 1)) && (waited < 20)) begin
      runCycles(1, 3'b111);
      waited++;
    end
    checks++;
    assert (waited < 20) else begin
      errors++;
      $error("[TB] FAIL tick_due_wait observed=%0d expected<20", waited);
    end
    applyStimulus(1'b1, 0, 7, 1'b0, 3'b111, 1'b0);
    runCycles(20, 3'b111);

    // Write to a nonexistent channel is ignored
    applyStimulus(1'b1, 3, 1, 1'b1, 3'b111, 1'b0);
    runCycles(10, 3'b111);

    // div 0 periodic on ch2: continuous ticks, counter saturates
    applyStimulus(1'b1, 2, 0, 1'b0, 3'b111, 1'b0);
    runCycles(22, 3'b111);
    applyStimulus(1'b1, 2, 0, 1'b0, 3'b111, 1'b0);
    runCycles(3, 3'b111);

    // Asynchronous reset mid-run
    rst_n = 1'b0;
    #1;
    resetModel();
    checkOutput();
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    runCycles(10, 3'b111);

    // Random traffic
    en_v = 3'b111;
    for (int n = 0; n < 400; n++) begin
      if ($urandom_range(0, 15) == 0) en_v[$urandom_range(0, CH-1)] ^= 1'b1;
      applyStimulus(($urandom_range(0, 7) == 0), int'($urandom_range(0, 3)),
                    int'($urandom_range(0, 9)), 1'($urandom_range(0, 1)),
                    en_v, ($urandom_range(0, 19) == 0));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
